tf_operand_loader: RTL
======================

Name: tf_operand_loader

Overview:
Upstream feeder for the 2x2 single-precision matrix-add stage. Accepts a serial stream of 32-bit IEEE-754 words over a valid/ready handshake and assembles two 2x2 matrices, A then B. It presents them as packed 128-bit buses with a strobe pair that the matrix adder consumes. Ping-pong buffering lets the next operand pair stream in while the current pair waits for the consumer.

Parameters:
WORD_W, 32, element width in bits (fixed; not intended to be overridden)
DIM, 2, matrix dimension (fixed at 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  32  operand word
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a word this cycle
in_last  input  1  marks the 8th (final) word of a frame
A  output  128  matrix A, element (m,n) at bits [(m*2+n)*32 +: 32]
B  output  128  matrix B, same packing as A
A_stb  output  1  A valid
B_stb  output  1  B valid (always equal to A_stb)
out_ack  input  1  one-cycle pulse from the consumer once it has captured A/B
frame_err  output  1  sticky framing-error flag
clear_err  input  1  clears frame_err

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset port "reset", clock "clk").
  - On reset, all slots are emptied; word counter, wr_ptr and rd_ptr are set to 0.
  - Output reset values: in_ready=1, A_stb=B_stb=0, A=B=0, frame_err=0.
- Frame format: 8 words.
  - Words 0..3 are A elements (0,0),(0,1),(1,0),(1,1).
  - Words 4..7 are B elements in the same order.
  - Word k lands in bits [(k mod 4)*32 +: 32] of A or B.
- Storage: two slots. Each slot holds 256 bits plus a full flag. wr_ptr selects the slot being filled; rd_ptr selects the slot being presented.
- Input handshake:
  - in_ready = !full[wr_ptr], registered-state based with no combinational dependency on in_valid.
  - A word is accepted when in_valid && in_ready, one word per cycle maximum.
- Frame completion: accepting word 7 with in_last=1 sets full[wr_ptr], toggles wr_ptr and resets the counter to 0.
- Framing errors:
  - in_last=1 on word 0..6: frame_err<=1, the partial frame is discarded, counter<=0, the slot stays empty.
  - Word 7 accepted with in_last=0: frame_err<=1, the frame is discarded, counter<=0.
- Output side:
  - A_stb = B_stb = full[rd_ptr].
  - A/B are driven from slot[rd_ptr] and held stable while strobed.
- Latency: strobes assert in the cycle after the edge that accepts word 7, provided the presented slot was empty.
- Consume: out_ack while A_stb clears full[rd_ptr] and toggles rd_ptr. If the other slot is full, strobes stay high and A/B switch to it in the next cycle. out_ack while A_stb=0 is ignored.
- Simultaneous events:
  - Frame completion and out_ack in the same cycle both take effect.
  - Completion and error in the same cycle cannot occur: the two are mutually exclusive by definition.
- Error flag: clear_err and a new error in the same cycle leave frame_err=1. Errors never block the data path.
- Throughput: with out_ack within 8 cycles of strobe, the loader sustains one word per cycle indefinitely.
- Reset mid-frame: the partial frame and all buffered frames are lost, and the next accepted word is treated as word 0.

Decomposition:
- Shared package tf_pkg holds:
  - WORD_W=32, DIM=2, MAT_W=128
  - WORDS_PER_MAT=4, WORDS_PER_FRAME=8
  - the element-offset function (m*DIM+n)*WORD_W, reused by the adder stage
- One sub-module is natural: tf_pingpong_buf.
  - It holds the two 256-bit slots, full flags and pointers.
  - Its interfaces are a write-word port and a read/ack port.
- The top level keeps the word counter, in_last checking and error flag.

Test Plan:
1. Reset with in_valid=0 -> in_ready=1, A_stb=B_stb=0, frame_err=0; out_ack pulses cause no change.
2. Words 1..8 (in_last on 8th) -> next cycle A_stb=B_stb=1; A[31:0]=1, A[127:96]=4, B[31:0]=5, B[127:96]=8; held until out_ack, then strobes drop next cycle.
3. Two frames (1..8, 9..16) with no ack -> in_ready=0 after 16th word and 17th word stalls; first ack -> A[31:0]=9 with strobe continuously high, in_ready=1 next cycle.
4. in_last on 3rd word -> frame_err=1, no strobe; following clean frame 0x3F800000 x8 delivered correctly; clear_err -> frame_err=0.
5. Reset asserted after 5 words, then a clean frame 21..28 -> A[31:0]=21, no residue from the aborted frame.
6. out_ack coincides with word 7 of the next frame while one slot is presented -> no lost frame, new frame presented next cycle, in_ready stays 1.

Source files
------------

// File: rtl/tf_pkg.sv
// Shared widths and element packing for the 2x2 single-precision matrix path.
package tf_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DIM             = 2;
  localparam int unsigned WORDS_PER_MAT   = DIM * DIM;
  localparam int unsigned WORDS_PER_FRAME = 2 * WORDS_PER_MAT;
  localparam int unsigned MAT_W           = WORDS_PER_MAT * WORD_W;
  localparam int unsigned SLOT_W          = WORDS_PER_FRAME * WORD_W;
  localparam int unsigned IDX_W           = $clog2(WORDS_PER_FRAME);

  // Bit offset of element (m,n) inside a packed matrix bus.
  function automatic int unsigned elem_off(input int unsigned m, input int unsigned n);
    return (m * DIM + n) * WORD_W;
  endfunction

endpackage

// File: rtl/tf_pingpong_buf.sv
// Two-slot frame buffer: one slot fills word by word while the other is presented.
module tf_pingpong_buf
  import tf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_full,
  output logic              rd_valid,
  output logic [SLOT_W-1:0] rd_data,
  input  logic              rd_ack
);

  logic [SLOT_W-1:0] slot_q [2];
  logic [1:0]        full_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;

  // Write words into the fill slot, mark it full on commit, release the read slot on ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) slot_q[i] <= '0;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (wr_en) begin
        slot_q[wr_ptr_q][int'(wr_idx) * WORD_W +: WORD_W] <= wr_data;
      end
      if (wr_en && wr_commit) begin
        full_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      // The fill slot is never full while writing, so these never target the same bit.
      if (rd_ack && full_q[rd_ptr_q]) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= ~rd_ptr_q;
      end
    end
  end

  assign wr_full  = full_q[wr_ptr_q];
  assign rd_valid = full_q[rd_ptr_q];
  assign rd_data  = slot_q[rd_ptr_q];

endmodule

// File: rtl/tf_operand_loader.sv
// Assembles 8-word frames into A/B 2x2 matrices and presents them with strobes.
module tf_operand_loader
  import tf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [MAT_W-1:0]  A,
  output logic [MAT_W-1:0]  B,
  output logic              A_stb,
  output logic              B_stb,
  input  logic              out_ack,
  output logic              frame_err,
  input  logic              clear_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);

  logic [IDX_W-1:0]  cnt_q;
  logic              err_q;
  logic              accept;
  logic              at_last;
  logic              commit;
  logic              bad_frame;
  logic              buf_full;
  logic              buf_valid;
  logic [SLOT_W-1:0] buf_data;

  assign accept    = in_valid && in_ready;
  assign at_last   = (cnt_q == LAST_IDX);
  assign commit    = at_last && in_last;
  assign bad_frame = accept && (at_last != in_last);

  tf_pingpong_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (accept),
    .wr_idx    (cnt_q),
    .wr_data   (in_data),
    .wr_commit (commit),
    .wr_full   (buf_full),
    .rd_valid  (buf_valid),
    .rd_data   (buf_data),
    .rd_ack    (out_ack)
  );

  // Word counter restarts on completion or any framing error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      if (at_last || in_last) cnt_q <= '0;
      else                    cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  // Sticky framing error; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         err_q <= 1'b0;
    else if (bad_frame) err_q <= 1'b1;
    else if (clear_err) err_q <= 1'b0;
  end

  // Element-wise unpack of the presented slot into the A and B buses.
  for (genvar m = 0; m < DIM; m++) begin : g_row
    for (genvar n = 0; n < DIM; n++) begin : g_col
      assign A[elem_off(m, n) +: WORD_W] = buf_data[elem_off(m, n) +: WORD_W];
      assign B[elem_off(m, n) +: WORD_W] = buf_data[MAT_W + elem_off(m, n) +: WORD_W];
    end
  end

  assign in_ready  = !buf_full;
  assign A_stb     = buf_valid;
  assign B_stb     = buf_valid;
  assign frame_err = err_q;

endmodule
